// File: rtl/sram_port_arbiter_if.sv
// Bundle of the CPU-side fetch/data ports and the unified SRAM port.
// slave  : arbiter view (consumes requests and SRAM read data, drives acks/returns/SRAM strobes)
// master : environment view (core requesters plus SRAM model)
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ack;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;
  // Data port
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;
  // SRAM port
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    output inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata, sram_rdata,
    input  inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Grant is combinational (ack in the request cycle); read data returns one cycle later,
// steered by the rd_owner flop.
// Ports:
//   clk    - clock, all state on the rising edge
//   resetn - asynchronous active-low reset
//   bus    - sram_port_arbiter_if.slave: fetch port, data port and SRAM port
// Build option ARB_ROUND_ROBIN_EN: when defined, contested cycles alternate winners
// (last_winner flop) instead of data priority with the STARVE_MAX starvation counter.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  sram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StNone, StInst, StData} owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   inst_gnt, data_gnt;
  logic   contested;

  assign contested = bus.inst_req & bus.data_req;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data won the last contested cycle; reset value (fetch) lets data win first.
  logic last_data_q, last_data_d;

  always_comb begin
    last_data_d = last_data_q;
    if (contested && resetn) begin
      last_data_d = data_gnt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.inst_req || inst_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (contested && data_gnt && (starve_cnt_q != 4'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Grant decode; held off while in reset so all strobes read 0.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (resetn) begin
      if (contested) begin
`ifdef ARB_ROUND_ROBIN_EN
        inst_gnt = last_data_q;
`else
        inst_gnt = (starve_cnt_q == 4'(STARVE_MAX));
`endif
        data_gnt = ~inst_gnt;
      end else begin
        inst_gnt = bus.inst_req;
        data_gnt = bus.data_req;
      end
    end
  end

  // SRAM mux and acks
  always_comb begin
    bus.inst_ack   = inst_gnt;
    bus.data_ack   = data_gnt;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (data_gnt) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.data_we;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (inst_gnt) begin
      bus.sram_en   = 1'b1;
      bus.sram_addr = bus.inst_addr;
    end
  end

  // Return owner: who consumes the SRAM output next cycle
  always_comb begin
    rd_owner_d = StNone;
    if (inst_gnt) begin
      rd_owner_d = StInst;
    end else if (data_gnt && !bus.data_we) begin
      rd_owner_d = StData;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_owner_q <= StNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.inst_rvalid = (rd_owner_q == StInst);
  assign bus.data_rvalid = (rd_owner_q == StData);
  assign bus.inst_rdata  = bus.sram_rdata;
  assign bus.data_rdata  = bus.sram_rdata;

endmodule
